// File: rtl/epc_pkg.sv
// Shared types and constants for the EPC StoredCRC generator.
// Residue check hardware is built only with EPC_CRC_RESIDUE_CHECK_EN.
package epc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      SHIFT,
      NEXT,
      FINISH
   } state_t;

   localparam logic [15:0] CRC16_PRESET  = 16'hFFFF;
   localparam logic [15:0] CRC16_POLY    = 16'h1021;
   localparam logic [15:0] CRC16_RESIDUE = 16'h1D0F;

   localparam int EPC_WORDS  = 33;
   localparam int PC_LEN_MSB = 15;
   localparam int PC_LEN_LSB = 11;

endpackage

// File: rtl/crc16_serial_core.sv
// Bit-serial CRC-16 register, MSB-first, non-reflected.
module crc16_serial_core
   import epc_pkg::*;
#(
   parameter logic [15:0] PRESET = CRC16_PRESET,
   parameter logic [15:0] POLY   = CRC16_POLY
) (
   input  logic        CRC_clk,
   input  logic        reset,
   input  logic        load,
   input  logic        en,
   input  logic        din,
   output logic [15:0] crc
);

   logic fb;

   assign fb = crc[15] ^ din;

   always_ff @(posedge CRC_clk or posedge reset) begin
      if (reset) begin
         crc <= PRESET;
      end else if (load) begin
         crc <= PRESET;
      end else if (en) begin
         crc <= {crc[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
      end
   end

endmodule

// File: rtl/epc_stored_crc_gen.sv
// Walks PC + EPC words through a serial CRC-16 and produces StoredCRC.
// Optional residue check over word 0: EPC_CRC_RESIDUE_CHECK_EN.
module epc_stored_crc_gen
   import epc_pkg::*;
#(
   parameter int          DATA_W     = 16,
   parameter int          ADDR_W     = 6,
   parameter logic [15:0] CRC_PRESET = CRC16_PRESET,
   parameter logic [15:0] CRC_POLY   = CRC16_POLY
) (
   input  logic              CRC_clk,
   input  logic              reset,
   input  logic              start,
   output logic              rd_en,
   output logic [ADDR_W-1:0] word_addr,
   input  logic [DATA_W-1:0] word_data,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] stored_crc,
   output logic              crc_bit,
   output logic              crc_bit_en,
   input  logic              check_mode,
   output logic              crc_ok
);

   localparam int LEN_W = PC_LEN_MSB - PC_LEN_LSB + 1;

   state_t             state;
   state_t             nxt;
   logic [DATA_W-1:0]  sreg;
   logic [3:0]         bcnt;
   logic [LEN_W-1:0]   len;
   logic [ADDR_W-1:0]  last_addr;
   logic [15:0]        crc;
   logic               chk;
   logic               more;
   logic               go_res;
   logic               accept;

   assign accept     = (state == IDLE) && start;
   assign last_addr  = ADDR_W'(len) + ADDR_W'(1);
   assign more       = (word_addr != '0) && (word_addr < last_addr);
   assign go_res     = chk && (word_addr != '0);
   assign rd_en      = (state == FETCH);
   assign busy       = (state != IDLE);
   assign crc_bit_en = (state == SHIFT);
   assign crc_bit    = crc_bit_en & sreg[DATA_W-1];

   crc16_serial_core #(
      .PRESET (CRC_PRESET),
      .POLY   (CRC_POLY)
   ) u_core (
      .CRC_clk (CRC_clk),
      .reset   (reset),
      .load    (accept),
      .en      (crc_bit_en),
      .din     (sreg[DATA_W-1]),
      .crc     (crc)
   );

   always_ff @(posedge CRC_clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:   if (start) nxt = FETCH;
         FETCH:  nxt = LOAD;
         LOAD:   nxt = SHIFT;
         SHIFT:  if (bcnt == 4'd0) nxt = NEXT;
         NEXT:   nxt = (more || go_res) ? FETCH : FINISH;
         FINISH: nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge CRC_clk or posedge reset) begin
      if (reset) begin
         word_addr  <= '0;
         sreg       <= '0;
         bcnt       <= '0;
         len        <= '0;
         stored_crc <= '0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: if (start) word_addr <= ADDR_W'(1);
            LOAD: begin
               sreg <= word_data;
               bcnt <= 4'd15;
               if (word_addr == ADDR_W'(1))
                  len <= word_data[PC_LEN_MSB:PC_LEN_LSB];
            end
            SHIFT: begin
               sreg <= {sreg[DATA_W-2:0], 1'b0};
               bcnt <= bcnt - 4'd1;
            end
            NEXT: begin
               if (more)        word_addr <= word_addr + ADDR_W'(1);
               else if (go_res) word_addr <= '0;
            end
            FINISH: begin
               done <= 1'b1;
               // a residue pass must not disturb the stored value
               if (!chk) stored_crc <= ~crc;
            end
            default: ;
         endcase
      end
   end

`ifdef EPC_CRC_RESIDUE_CHECK_EN
   always_ff @(posedge CRC_clk or posedge reset) begin
      if (reset) begin
         chk    <= 1'b0;
         crc_ok <= 1'b0;
      end else if (accept) begin
         chk    <= check_mode;
         crc_ok <= 1'b0;
      end else if (state == FINISH && chk) begin
         crc_ok <= (crc == CRC16_RESIDUE);
      end
   end
`else
   logic unused_check_mode;
   assign unused_check_mode = check_mode;
   assign chk               = 1'b0;
   assign crc_ok            = 1'b0;
`endif

endmodule

// File: tb/tb_epc_stored_crc_gen.sv
// Scoreboard bench for epc_stored_crc_gen against a byte-wise GENIBUS model.
module tb_epc_stored_crc_gen;

`ifdef EPC_CRC_RESIDUE_CHECK_EN
   localparam bit RES_EN = 1'b1;
`else
   localparam bit RES_EN = 1'b0;
`endif

   logic        CRC_clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        check_mode = 1'b0;
   logic [15:0] word_data = 16'h0;
   logic        rd_en, busy, done, crc_bit, crc_bit_en, crc_ok;
   logic [5:0]  word_addr;
   logic [15:0] stored_crc;

   epc_stored_crc_gen dut (
      .CRC_clk    (CRC_clk),
      .reset      (reset),
      .start      (start),
      .rd_en      (rd_en),
      .word_addr  (word_addr),
      .word_data  (word_data),
      .busy       (busy),
      .done       (done),
      .stored_crc (stored_crc),
      .crc_bit    (crc_bit),
      .crc_bit_en (crc_bit_en),
      .check_mode (check_mode),
      .crc_ok     (crc_ok)
   );

   always #5 CRC_clk = ~CRC_clk;

   typedef struct {
      int          lat;
      logic [15:0] crc;
      logic        ok;
      int          nbits;
      int          nrd;
      int          start_cyc;
   } exp_t;

   exp_t        exp_q[$];
   logic        exp_bits[$];
   int          exp_addr[$];
   int          vecs = 0;
   int          miss = 0;
   int          cyc = 0;
   logic [15:0] mem[0:32];
   logic [15:0] last_crc = 16'h0;

   // synchronous-read memory: data valid the cycle after rd_en
   always @(posedge CRC_clk) begin
      cyc <= cyc + 1;
      if (rd_en) word_data <= mem[word_addr];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] genibus(input logic [15:0] w[$]);
      logic [15:0] c;
      logic [7:0]  b;
      c = 16'hFFFF;
      foreach (w[i]) begin
         for (int h = 0; h < 2; h++) begin
            b = (h == 0) ? w[i][15:8] : w[i][7:0];
            c ^= {b, 8'h00};
            for (int k = 0; k < 8; k++)
               c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
         end
      end
      return ~c;
   endfunction

   exp_t e_m;
   int   nb = 0, nr = 0, berr = 0, aerr = 0;

   always @(negedge CRC_clk) begin
      if (reset) begin
         nb = 0; nr = 0; berr = 0; aerr = 0;
      end else begin
         if (crc_bit_en) begin
            nb++;
            if (exp_bits.size() == 0) berr++;
            else if (exp_bits.pop_front() !== crc_bit) berr++;
         end
         if (rd_en) begin
            nr++;
            if (exp_addr.size() == 0) aerr++;
            else if (exp_addr.pop_front() != int'(word_addr)) aerr++;
         end
         if (done) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e_m = exp_q.pop_front();
               chk("latency", cyc - e_m.start_cyc + 1, e_m.lat);
               chk("stored_crc", stored_crc, e_m.crc);
               chk("crc_ok", crc_ok, e_m.ok);
               chk("bit_en_count", nb, e_m.nbits);
               chk("rd_count", nr, e_m.nrd);
               chk("bit_stream_errs", berr, 0);
               chk("addr_seq_errs", aerr, 0);
            end
            nb = 0; nr = 0; berr = 0; aerr = 0;
         end
      end
   end

   task automatic push_word(input int a);
      exp_addr.push_back(a);
      for (int b = 15; b >= 0; b--) exp_bits.push_back(mem[a][b]);
   endtask

   task automatic run(input logic cm);
      logic [15:0] w[$];
      exp_t        e;
      int          L, n;
      bit          res;
      L = int'(mem[1][15:11]);
      for (int i = 1; i <= L + 1; i++) begin
         w.push_back(mem[i]);
         push_word(i);
      end
      res = cm && RES_EN;
      if (res) push_word(0);
      n       = L + 1 + int'(res);
      e.crc   = res ? last_crc : genibus(w);
      e.ok    = res && (mem[0] == genibus(w));
      e.lat   = 2 + 19 * n;
      e.nbits = 16 * n;
      e.nrd   = n;
      @(negedge CRC_clk);
      start      = 1'b1;
      check_mode = cm;
      e.start_cyc = cyc + 1;
      exp_q.push_back(e);
      @(negedge CRC_clk);
      start      = 1'b0;
      check_mode = 1'b0;
      for (int t = 0; t < 800 && exp_q.size() != 0; t++) @(negedge CRC_clk);
      if (exp_q.size() != 0) begin
         chk("done_timeout", 1, 0);
         exp_q.delete();
         exp_bits.delete();
         exp_addr.delete();
      end
      if (!res) last_crc = e.crc;
      @(negedge CRC_clk);
   endtask

   initial begin
      for (int i = 0; i < 33; i++) mem[i] = 16'h0;
      repeat (2) @(negedge CRC_clk);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_word_addr", word_addr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_crc_bit", crc_bit, 0);
      chk("rst_crc_bit_en", crc_bit_en, 0);
      chk("rst_crc_ok", crc_ok, 0);
      chk("rst_stored_crc", stored_crc, 0);
      reset = 1'b0;
      @(negedge CRC_clk);

      mem[1] = 16'h0800;
      mem[2] = 16'h3132;
      run(1'b0);
      mem[0] = last_crc;
      run(1'b1);
      mem[0] = last_crc ^ 16'h0001;
      run(1'b1);

      for (int i = 0; i < 33; i++) mem[i] = 16'h0;
      run(1'b0);

      for (int i = 0; i < 33; i++) mem[i] = 16'hFFFF;
      mem[1] = 16'hF800;
      run(1'b0);

      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 33; i++) mem[i] = 16'($urandom);
         run(1'b0);
         mem[0] = ($urandom_range(0, 1) == 1) ? last_crc : 16'($urandom);
         run(1'b1);
      end

      mem[1] = 16'h0800;
      mem[2] = 16'h3132;
      @(negedge CRC_clk);
      start = 1'b1;
      @(negedge CRC_clk);
      start = 1'b0;
      repeat (3) @(negedge CRC_clk);
      start = 1'b1;
      @(negedge CRC_clk);
      start = 1'b0;
      repeat (4) @(negedge CRC_clk);
      reset = 1'b1;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_stored_crc", stored_crc, 0);
      chk("abort_done", done, 0);
      @(negedge CRC_clk);
      reset = 1'b0;
      repeat (60) @(negedge CRC_clk);
      chk("abort_idle_busy", busy, 0);
      last_crc = 16'h0;
      run(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule
